// File: rtl/opa_pkg.sv
// -----------------------------------------------------------------------------
// opa_pkg
// Definitions shared by the operand-A select stage, the ALU and the hazard
// unit. It holds the a_src encodings, the default datapath widths and small
// helpers for decoding a_src.
//
// Optional feature macro: OPA_FWD_EN. The macro has no effect in this package.
// It enables EX/MEM forwarding inside opa_fwd_sel.
// -----------------------------------------------------------------------------
package opa_pkg;

   // Default widths. Instantiations may override them.
   localparam int OPA_WIDTH   = 32;
   localparam int OPA_SHAMT_W = 5;
   localparam int OPA_REG_AW  = 5;

   typedef logic [1:0] opa_src_t;

   // Encodings for the a_src output.
   localparam logic [1:0] OPA_SRC_RF    = 2'd0;
   localparam logic [1:0] OPA_SRC_SHAMT = 2'd1;
   localparam logic [1:0] OPA_SRC_EXF   = 2'd2;
   localparam logic [1:0] OPA_SRC_MEMF  = 2'd3;

   // Both forward encodings have bit 1 set. The hazard unit tests only that bit.
   function automatic logic opa_src_is_fwd(input opa_src_t s);
      return s[1];
   endfunction

   // Returns 1 when the operand came from the instruction word and not from a register.
   function automatic logic opa_src_is_imm(input opa_src_t s);
      return (s == OPA_SRC_SHAMT);
   endfunction

endpackage

// File: rtl/opa_fwd_sel.sv
// -----------------------------------------------------------------------------
// opa_fwd_sel
// Combinational priority select that produces the next operand A and its
// source tag. Priority order, highest first:
//   1. shift amount (eshift)
//   2. EX-stage forward   (OPA_FWD_EN only)
//   3. MEM-stage forward  (OPA_FWD_EN only)
//   4. register-file data
//
// Optional feature macro: OPA_FWD_EN. When the macro is undefined, the ex_* and
// mem_* inputs are ignored and only the RF or SHAMT source can be selected.
//
// Ports:
//   rs_addr, rs_data        source register number and its regfile value
//   shamt, eshift           shift-amount field and its select
//   ex_wr_en/addr/data      EX-stage writeback candidate
//   mem_wr_en/addr/data     MEM-stage writeback candidate
//   nxt_a, nxt_src          selected operand and its a_src encoding
// -----------------------------------------------------------------------------
module opa_fwd_sel
   import opa_pkg::*;
#(
   parameter int WIDTH   = OPA_WIDTH,
   parameter int SHAMT_W = OPA_SHAMT_W,
   parameter int REG_AW  = OPA_REG_AW
) (
   input  logic [REG_AW-1:0]  rs_addr,
   input  logic [WIDTH-1:0]   rs_data,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               eshift,
   input  logic               ex_wr_en,
   input  logic [REG_AW-1:0]  ex_wr_addr,
   input  logic [WIDTH-1:0]   ex_wr_data,
   input  logic               mem_wr_en,
   input  logic [REG_AW-1:0]  mem_wr_addr,
   input  logic [WIDTH-1:0]   mem_wr_data,
   output logic [WIDTH-1:0]   nxt_a,
   output logic [1:0]         nxt_src
);

   logic [WIDTH-1:0] sh_ext;

   // This form of zero-extension also works when SHAMT_W == WIDTH. In that
   // case a replication count would be zero.
   always_comb begin
      sh_ext                = '0;
      sh_ext[SHAMT_W-1:0]   = shamt;
   end

`ifdef OPA_FWD_EN
   logic rs_nz;
   logic ex_hit;
   logic mem_hit;

   // Register 0 is hard-wired, so a pending write to it is never forwarded.
   assign rs_nz   = (rs_addr != '0);
   assign ex_hit  = ex_wr_en  && (ex_wr_addr  == rs_addr) && rs_nz;
   assign mem_hit = mem_wr_en && (mem_wr_addr == rs_addr) && rs_nz;

   always_comb begin
      nxt_a   = rs_data;
      nxt_src = OPA_SRC_RF;
      if (eshift) begin
         nxt_a   = sh_ext;
         nxt_src = OPA_SRC_SHAMT;
      end else if (ex_hit) begin
         // EX holds the younger result, so it wins over MEM.
         nxt_a   = ex_wr_data;
         nxt_src = OPA_SRC_EXF;
      end else if (mem_hit) begin
         nxt_a   = mem_wr_data;
         nxt_src = OPA_SRC_MEMF;
      end
   end
`else
   // The forwarding ports stay in the port list so the wiring does not change
   // between builds. Their values are not used in this build.
   logic unused_fwd;
   assign unused_fwd = ^{rs_addr, ex_wr_en, ex_wr_addr, ex_wr_data,
                         mem_wr_en, mem_wr_addr, mem_wr_data};

   always_comb begin
      nxt_a   = rs_data;
      nxt_src = OPA_SRC_RF;
      if (eshift) begin
         nxt_a   = sh_ext;
         nxt_src = OPA_SRC_SHAMT;
      end
   end
`endif

endmodule

// File: rtl/opa_select_pipe.sv
// -----------------------------------------------------------------------------
// opa_select_pipe
// ALU operand-A select, registered at the ID/EX boundary behind a
// valid/ready handshake. The stage holds one entry. When the entry is
// consumed and a new operand is captured in the same cycle, the stage
// sustains one operand per cycle.
//
// Optional feature macro: OPA_FWD_EN. It enables EX/MEM forwarding in opa_fwd_sel.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   flush                 drops the held operand and any same-cycle capture
//   in_valid / in_ready   request handshake from decode
//   rs_addr, rs_data      source register and regfile data
//   shamt, eshift         shift-amount field and its select
//   ex_wr_*, mem_wr_*     forwarding candidates from the EX and MEM stages
//   out_valid / out_ready operand handshake to the ALU
//   a, a_src              registered operand and its source encoding
// -----------------------------------------------------------------------------
module opa_select_pipe
   import opa_pkg::*;
#(
   parameter int WIDTH   = OPA_WIDTH,
   parameter int SHAMT_W = OPA_SHAMT_W,
   parameter int REG_AW  = OPA_REG_AW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [REG_AW-1:0]  rs_addr,
   input  logic [WIDTH-1:0]   rs_data,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               eshift,
   input  logic               ex_wr_en,
   input  logic [REG_AW-1:0]  ex_wr_addr,
   input  logic [WIDTH-1:0]   ex_wr_data,
   input  logic               mem_wr_en,
   input  logic [REG_AW-1:0]  mem_wr_addr,
   input  logic [WIDTH-1:0]   mem_wr_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   a,
   output logic [1:0]         a_src
);

   logic [WIDTH-1:0] nxt_a;
   logic [1:0]       nxt_src;
   logic             cap;

   opa_fwd_sel #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .REG_AW  (REG_AW)
   ) u_sel (
      .rs_addr     (rs_addr),
      .rs_data     (rs_data),
      .shamt       (shamt),
      .eshift      (eshift),
      .ex_wr_en    (ex_wr_en),
      .ex_wr_addr  (ex_wr_addr),
      .ex_wr_data  (ex_wr_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .nxt_a       (nxt_a),
      .nxt_src     (nxt_src)
   );

   // The slot is free when it is empty or is being drained this cycle.
   assign in_ready = !out_valid || out_ready;

   // Data registers load only on a real capture. This keeps don't-care
   // request fields out of the state while in_valid is low.
   assign cap = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         a         <= '0;
         a_src     <= OPA_SRC_RF;
      end else if (flush) begin
         // Flush creates a bubble. The stale operand stays on a.
         out_valid <= 1'b0;
      end else if (cap) begin
         out_valid <= 1'b1;
         a         <= nxt_a;
         a_src     <= nxt_src;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
